// File: rtl/time_counter.sv
// time_counter: 24 h hour:min:sec timekeeping core with a 1 s prescaler,
// adjust-mode field stepping on flag rising edges, and a blink strobe for
// the field under adjustment. All state is binary and clocked on sys_clk.
module time_counter #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       min_en,
  input  logic       hour_en,
  input  logic       min_add_flag,
  input  logic       min_sub_flag,
  input  logic       hour_add_flag,
  input  logic       hour_sub_flag,
  output logic [4:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       sec_pulse,
  output logic       blink
);

  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_TERM = PW'(CLK_FREQ - 1);
  localparam logic [BW-1:0] BLINK_TERM = BW'(BLINK_DIV - 1);

  logic [PW-1:0] r_presc;
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink;
  logic          r_sec_pulse;
  logic [4:0]    r_hour;
  logic [5:0]    r_min;
  logic [5:0]    r_sec;
  logic          r_min_add_d;
  logic          r_min_sub_d;
  logic          r_hour_add_d;
  logic          r_hour_sub_d;

  logic w_adj;
  logic w_presc_tc;
  logic w_min_add_rise;
  logic w_min_sub_rise;
  logic w_hour_add_rise;
  logic w_hour_sub_rise;

  assign w_adj           = hour_en | min_en;
  assign w_presc_tc      = (r_presc == PRESC_TERM);
  assign w_min_add_rise  = min_add_flag  & ~r_min_add_d;
  assign w_min_sub_rise  = min_sub_flag  & ~r_min_sub_d;
  assign w_hour_add_rise = hour_add_flag & ~r_hour_add_d;
  assign w_hour_sub_rise = hour_sub_flag & ~r_hour_sub_d;

  // 1 s prescaler and its one-cycle seconds strobe; held clear while adjusting.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_presc     <= '0;
      r_sec_pulse <= 1'b0;
    end else if (w_adj) begin
      r_presc     <= '0;
      r_sec_pulse <= 1'b0;
    end else if (w_presc_tc) begin
      r_presc     <= '0;
      r_sec_pulse <= 1'b1;
    end else begin
      r_presc     <= r_presc + PW'(1);
      r_sec_pulse <= 1'b0;
    end
  end

  // Time fields: carry chain in run mode, independent wrapped stepping in adjust mode.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_hour <= '0;
      r_min  <= '0;
      r_sec  <= '0;
    end else if (w_adj) begin
      r_sec <= '0;
      // Add takes priority when both edges land on the same cycle.
      if (hour_en) begin
        if (w_hour_add_rise)
          r_hour <= (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
        else if (w_hour_sub_rise)
          r_hour <= (r_hour == 5'd0) ? 5'd23 : r_hour - 5'd1;
      end
      if (min_en) begin
        if (w_min_add_rise)
          r_min <= (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
        else if (w_min_sub_rise)
          r_min <= (r_min == 6'd0) ? 6'd59 : r_min - 6'd1;
      end
    end else if (w_presc_tc) begin
      if (r_sec == 6'd59) begin
        r_sec <= '0;
        if (r_min == 6'd59) begin
          r_min  <= '0;
          r_hour <= (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
        end else begin
          r_min <= r_min + 6'd1;
        end
      end else begin
        r_sec <= r_sec + 6'd1;
      end
    end
  end

  // Blink divider: free-runs only in adjust mode, parked at zero otherwise.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (!w_adj) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (r_blink_cnt == BLINK_TERM) begin
      r_blink_cnt <= '0;
      r_blink     <= ~r_blink;
    end else begin
      r_blink_cnt <= r_blink_cnt + BW'(1);
    end
  end

  // Flag delay registers track every cycle so edges are detected cleanly on enable.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_min_add_d  <= 1'b0;
      r_min_sub_d  <= 1'b0;
      r_hour_add_d <= 1'b0;
      r_hour_sub_d <= 1'b0;
    end else begin
      r_min_add_d  <= min_add_flag;
      r_min_sub_d  <= min_sub_flag;
      r_hour_add_d <= hour_add_flag;
      r_hour_sub_d <= hour_sub_flag;
    end
  end

  // Gating blink with adj clears it in the very first cycle after leaving adjust.
  assign blink     = r_blink & w_adj;
  assign hour      = r_hour;
  assign min       = r_min;
  assign sec       = r_sec;
  assign sec_pulse = r_sec_pulse;

endmodule

// File: tb/tb_time_counter.sv
// Self-checking bench for time_counter with CLK_FREQ=10, BLINK_DIV=4.
// Expected seconds strobes (arrival cycle and time value) are queued when a
// run interval is started and compared by a monitor when sec_pulse appears.
module tb_time_counter;

  localparam int CLK_FREQ  = 10;
  localparam int BLINK_DIV = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       min_en = 1'b0;
  logic       hour_en = 1'b0;
  logic       min_add_flag = 1'b0;
  logic       min_sub_flag = 1'b0;
  logic       hour_add_flag = 1'b0;
  logic       hour_sub_flag = 1'b0;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic       sec_pulse;
  logic       blink;

  time_counter #(
    .CLK_FREQ (CLK_FREQ),
    .BLINK_DIV(BLINK_DIV)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .min_en       (min_en),
    .hour_en      (hour_en),
    .min_add_flag (min_add_flag),
    .min_sub_flag (min_sub_flag),
    .hour_add_flag(hour_add_flag),
    .hour_sub_flag(hour_sub_flag),
    .hour         (hour),
    .min          (min),
    .sec          (sec),
    .sec_pulse    (sec_pulse),
    .blink        (blink)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int at;
    int h;
    int m;
    int s;
  } exp_t;

  exp_t sb[$];
  int m_h = 0;
  int m_m = 0;
  int m_s = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Stimulus changes land 1 time unit after the falling edge, after the monitor sampled.
  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
    #1;
  endtask

  task automatic set_flags(input logic [3:0] f);
    {hour_add_flag, hour_sub_flag, min_add_flag, min_sub_flag} = f;
  endtask

  task automatic pulse(input logic [3:0] f);
    set_flags(f);
    tick(1);
    set_flags(4'b0000);
    tick(1);
  endtask

  task automatic advance_model();
    m_s++;
    if (m_s == 60) begin
      m_s = 0;
      m_m++;
      if (m_m == 60) begin
        m_m = 0;
        m_h++;
        if (m_h == 24) m_h = 0;
      end
    end
  endtask

  // Must be called with the prescaler at zero (just after reset release,
  // adjust exit, or a previous run_secs).
  task automatic run_secs(input int k);
    for (int j = 1; j <= k; j++) begin
      advance_model();
      sb.push_back('{cyc + CLK_FREQ * j, m_h, m_m, m_s});
    end
    tick(CLK_FREQ * k);
    check("pulses_consumed", sb.size(), 0);
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, "_hour"}, 32'(hour), h);
    check({tag, "_min"},  32'(min),  m);
    check({tag, "_sec"},  32'(sec),  s);
  endtask

  // Scoreboard consumer: every sec_pulse must match the oldest queued expectation.
  always @(negedge sys_clk) begin
    exp_t e;
    if (sys_rst_n && sec_pulse === 1'b1) begin
      check("pulse_expected", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pulse_cycle", cyc, e.at);
        check("pulse_hour", 32'(hour), e.h);
        check("pulse_min",  32'(min),  e.m);
        check("pulse_sec",  32'(sec),  e.s);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(3);
    check_time("reset", 0, 0, 0);
    check("reset_sec_pulse", 32'(sec_pulse), 0);
    check("reset_blink", 32'(blink), 0);

    // 1: free run, pulses at 10/20/30 cycles after release
    sys_rst_n = 1'b1;
    run_secs(3);
    check_time("run3", 0, 0, 3);
    check("run_blink", 32'(blink), 0);

    // 2: preload 23:59:59 and roll over on one edge
    hour_en = 1'b1;
    tick(1);
    m_s = 0;
    check("adj_sec_zero", 32'(sec), 0);
    repeat (23) pulse(4'b1000);
    m_h = 23;
    check("preload_hour", 32'(hour), 23);
    hour_en = 1'b0;
    min_en  = 1'b1;
    repeat (59) pulse(4'b0010);
    m_m = 59;
    check("preload_min", 32'(min), 59);
    min_en = 1'b0;
    run_secs(59);
    check_time("pre_wrap", 23, 59, 59);
    run_secs(1);
    check_time("post_wrap", 0, 0, 0);

    // 3: hour sub wrap, then hour_add held 5 cycles at 23 -> exactly one step
    hour_en = 1'b1;
    pulse(4'b0100);
    check("hour_sub_wrap", 32'(hour), 23);
    set_flags(4'b1000);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("hold_hour", 32'(hour), 0);
      check("hold_sec", 32'(sec), 0);
      check("hold_sec_pulse", 32'(sec_pulse), 0);
    end
    set_flags(4'b0000);
    tick(1);
    m_h = 0;
    check("hold_min", 32'(min), 0);
    pulse(4'b0010);
    check("min_flag_ignored", 32'(min), 0);

    // 4: minute sub wrap, simultaneous add/sub -> add wins, hour untouched
    hour_en = 1'b0;
    min_en  = 1'b1;
    pulse(4'b0001);
    check("min_sub_wrap", 32'(min), 59);
    check("min_sub_no_borrow", 32'(hour), 0);
    pulse(4'b0011);
    check("min_add_wins", 32'(min), 0);
    check("min_add_no_carry", 32'(hour), 0);
    pulse(4'b1000);
    check("hour_flag_ignored", 32'(hour), 0);
    min_en = 1'b0;
    m_m = 0;
    run_secs(1);

    // 5: blink cadence in adjust, clear on exit, pulse CLK_FREQ cycles later
    min_en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      check("blink_cadence", 32'(blink), (k / 4) % 2);
    end
    check("blink_adj_sec", 32'(sec), 0);
    min_en = 1'b0;
    #1;
    check("blink_exit", 32'(blink), 0);
    m_s = 0;
    run_secs(1);
    check_time("after_blink", 0, 0, 1);

    // 6a: reset mid-count
    tick(5);
    check("mid_count_sec", 32'(sec), 1);
    sys_rst_n = 1'b0;
    #1;
    check_time("rst_count", 0, 0, 0);
    check("rst_count_pulse", 32'(sec_pulse), 0);
    tick(1);
    sys_rst_n = 1'b1;

    // 6b: reset mid-adjust with flags held high
    hour_en = 1'b1;
    repeat (3) pulse(4'b1000);
    set_flags(4'b1010);
    tick(1);
    check("mid_adj_hour", 32'(hour), 4);
    check("mid_adj_blink", 32'(blink), 1);
    sys_rst_n = 1'b0;
    #1;
    check_time("rst_adj", 0, 0, 0);
    check("rst_adj_blink", 32'(blink), 0);
    check("rst_adj_pulse", 32'(sec_pulse), 0);
    tick(2);
    check("rst_hold_hour", 32'(hour), 0);
    set_flags(4'b0000);
    hour_en = 1'b0;
    tick(1);
    sys_rst_n = 1'b1;
    m_h = 0;
    m_m = 0;
    m_s = 0;
    run_secs(1);
    check_time("post_reset", 0, 0, 1);

    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
